// File: rtl/mult_iter_pkg.sv
// Shared types and sizing helpers for the iterative chunked multiplier.
package mult_iter_pkg;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        FIX,
        DONE
    } mult_iter_state_t;

    function automatic int chunkCount(input int width, input int chunkW);
        return width / chunkW;
    endfunction

    // Counter width for n chunks, never narrower than one bit.
    function automatic int idxWidth(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mult_iter_if.sv
// Start/busy/done handshake and operand/result bus of the iterative multiplier.
interface mult_iter_if #(
    parameter int A_W = 32,
    parameter int B_W = 32
);
    logic                 start;
    logic                 signed_mode;
    logic [A_W-1:0]       a;
    logic [B_W-1:0]       b;
    logic                 busy;
    logic                 done;
    logic [A_W+B_W-1:0]   product;

    modport master (
        output start, signed_mode, a, b,
        input  busy, done, product
    );

    modport slave (
        input  start, signed_mode, a, b,
        output busy, done, product
    );
endinterface

// File: rtl/mult_iter_fsm.sv
// Controller: sequences the NA x NB chunk products, the sign fix-up and the done pulse.
module mult_iter_fsm
    import mult_iter_pkg::*;
#(
    parameter int NA = 2,
    parameter int NB = 2,
    parameter int IW = idxWidth(NA),
    parameter int JW = idxWidth(NB)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start_i,
    output logic          clr_prod_o,
    output logic          upd_prod_o,
    output logic          neg_en_o,
    output logic          busy_o,
    output logic          done_o,
    output logic [IW-1:0] i_o,
    output logic [JW-1:0] j_o
);

    localparam logic [IW-1:0] I_LAST = IW'(NA - 1);
    localparam logic [JW-1:0] J_LAST = JW'(NB - 1);

    mult_iter_state_t state_q;
    logic [IW-1:0]    i_q;
    logic [JW-1:0]    j_q;
    logic             busy_q;
    logic             done_q;

    // i walks the multiplicand chunks fastest; j advances once per full row.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            i_q     <= '0;
            j_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        state_q <= MUL;
                        busy_q  <= 1'b1;
                        i_q     <= '0;
                        j_q     <= '0;
                    end
                end
                MUL: begin
                    if (i_q == I_LAST) begin
                        i_q <= '0;
                        if (j_q == J_LAST) begin
                            j_q     <= '0;
                            state_q <= FIX;
                        end else begin
                            j_q <= j_q + JW'(1);
                        end
                    end else begin
                        i_q <= i_q + IW'(1);
                    end
                end
                FIX: begin
                    state_q <= DONE;
                    done_q  <= 1'b1;
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign clr_prod_o = (state_q == IDLE) && start_i;
    assign upd_prod_o = (state_q == MUL);
    assign neg_en_o   = (state_q == FIX);
    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign i_o        = i_q;
    assign j_o        = j_q;

endmodule

// File: rtl/mult_iter.sv
// Iterative A_W x B_W multiplier: one CHUNK_W x CHUNK_W partial product per cycle,
// magnitudes multiplied and the sign applied in a final fix-up cycle.
module mult_iter
    import mult_iter_pkg::*;
#(
    parameter int A_W     = 32,
    parameter int B_W     = 32,
    parameter int CHUNK_W = 16
) (
    input  logic       clk,
    input  logic       reset,
    mult_iter_if.slave bus
);

    localparam int NA = chunkCount(A_W, CHUNK_W);
    localparam int NB = chunkCount(B_W, CHUNK_W);
    localparam int PW = A_W + B_W;
    localparam int IW = idxWidth(NA);
    localparam int JW = idxWidth(NB);

    if ((A_W % CHUNK_W) != 0 || (B_W % CHUNK_W) != 0) begin : gBadParams
        $error("mult_iter: A_W and B_W must be multiples of CHUNK_W");
    end

    logic          clrProd;
    logic          updProd;
    logic          negEn;
    logic          busy;
    logic          done;
    logic [IW-1:0] chunkI;
    logic [JW-1:0] chunkJ;

    mult_iter_fsm #(
        .NA (NA),
        .NB (NB),
        .IW (IW),
        .JW (JW)
    ) u_fsm (
        .clk        (clk),
        .reset      (reset),
        .start_i    (bus.start),
        .clr_prod_o (clrProd),
        .upd_prod_o (updProd),
        .neg_en_o   (negEn),
        .busy_o     (busy),
        .done_o     (done),
        .i_o        (chunkI),
        .j_o        (chunkJ)
    );

    logic [A_W-1:0]       aMag_q;
    logic [B_W-1:0]       bMag_q;
    logic                 neg_q;
    logic [PW-1:0]        product_q;
    logic [PW-1:0]        product_d;
    logic [CHUNK_W-1:0]   aChunk;
    logic [CHUNK_W-1:0]   bChunk;
    logic [2*CHUNK_W-1:0] partial;
    int                   aOff;
    int                   bOff;
    int                   shAmt;

    always_comb begin
        aOff      = int'(chunkI) * CHUNK_W;
        bOff      = int'(chunkJ) * CHUNK_W;
        shAmt     = aOff + bOff;
        aChunk    = aMag_q[aOff +: CHUNK_W];
        bChunk    = bMag_q[bOff +: CHUNK_W];
        partial   = {{CHUNK_W{1'b0}}, aChunk} * {{CHUNK_W{1'b0}}, bChunk};
        product_d = product_q;
        if (clrProd) begin
            product_d = '0;
        end else if (updProd) begin
            product_d = product_q + (PW'(partial) << shAmt);
        end else if (negEn && neg_q) begin
            product_d = ~product_q + PW'(1);
        end
    end

    // Operands are reduced to magnitudes at accept; the most negative value still fits unsigned.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            aMag_q    <= '0;
            bMag_q    <= '0;
            neg_q     <= 1'b0;
            product_q <= '0;
        end else begin
            product_q <= product_d;
            if (clrProd) begin
                aMag_q <= (bus.signed_mode && bus.a[A_W-1]) ? (~bus.a + A_W'(1)) : bus.a;
                bMag_q <= (bus.signed_mode && bus.b[B_W-1]) ? (~bus.b + B_W'(1)) : bus.b;
                neg_q  <= bus.signed_mode && (bus.a[A_W-1] ^ bus.b[B_W-1]);
            end
        end
    end

    assign bus.busy    = busy;
    assign bus.done    = done;
    assign bus.product = product_q;

endmodule

// File: tb/tb_mult_iter.sv
// Scoreboard bench for mult_iter: a 32x32/16 instance and a 16x24/8 variant on one clock.
module tb_mult_iter;

    logic clk = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    logic [63:0] q32[$];
    logic [63:0] q8[$];

    always #5 clk = ~clk;

    mult_iter_if #(.A_W(32), .B_W(32)) bus32 ();
    mult_iter_if #(.A_W(16), .B_W(24)) bus8 ();

    mult_iter #(.A_W(32), .B_W(32), .CHUNK_W(16)) dut32 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus32)
    );

    mult_iter #(.A_W(16), .B_W(24), .CHUNK_W(8)) dut8 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus8)
    );

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Monitors pop the oldest expected product whenever a done pulse appears.
    always @(negedge clk) begin
        if (!reset && bus32.done) begin
            if (q32.size() == 0) checkOutput("unexpectedDone32", 64'(bus32.done), 64'd0);
            else checkOutput("product32", bus32.product, q32.pop_front());
        end
    end

    always @(negedge clk) begin
        if (!reset && bus8.done) begin
            if (q8.size() == 0) checkOutput("unexpectedDone8", 64'(bus8.done), 64'd0);
            else checkOutput("product8", {24'd0, bus8.product}, q8.pop_front());
        end
    end

    function automatic logic [63:0] refProduct8(input logic sm, input logic [15:0] a, input logic [23:0] b);
        logic [39:0] ea;
        logic [39:0] eb;
        logic [39:0] p;
        ea = sm ? {{24{a[15]}}, a} : {24'd0, a};
        eb = sm ? {{16{b[23]}}, b} : {16'd0, b};
        p  = ea * eb;
        return {24'd0, p};
    endfunction

    function automatic logic curDone(input int sel);
        return (sel != 0) ? bus8.done : bus32.done;
    endfunction

    function automatic logic curBusy(input int sel);
        return (sel != 0) ? bus8.busy : bus32.busy;
    endfunction

    task automatic driveOps(input int sel, input logic sm, input logic [31:0] a, input logic [31:0] b, input logic st);
        if (sel != 0) begin
            bus8.start       = st;
            bus8.signed_mode = sm;
            bus8.a           = a[15:0];
            bus8.b           = b[23:0];
        end else begin
            bus32.start       = st;
            bus32.signed_mode = sm;
            bus32.a           = a;
            bus32.b           = b;
        end
    endtask

    // Issues one multiply, scrambles the inputs after accept and times done/busy.
    task automatic applyStimulus(input int sel, input logic sm, input logic [31:0] a, input logic [31:0] b,
                                 input logic [63:0] expected, input int disturbAt, input string tag);
        int   np;
        int   doneAt;
        int   doneCnt;
        logic busyOk;
        logic busyAfter;
        np        = (sel != 0) ? 6 : 4;
        doneAt    = -1;
        doneCnt   = 0;
        busyOk    = 1'b1;
        busyAfter = 1'b1;
        if (sel != 0) q8.push_back(expected);
        else q32.push_back(expected);
        @(negedge clk);
        driveOps(sel, sm, a, b, 1'b1);
        @(posedge clk);
        #1 driveOps(sel, ~sm, ~a, a ^ b, 1'b0);
        for (int c = 1; c <= np + 6; c++) begin
            @(negedge clk);
            if (curDone(sel)) begin
                doneCnt++;
                if (doneAt < 0) doneAt = c;
            end
            if (c <= np + 2 && !curBusy(sel)) busyOk = 1'b0;
            if (c == np + 3) busyAfter = curBusy(sel);
            if (c == disturbAt) driveOps(sel, ~sm, b, a, 1'b1);
            if (c == disturbAt + 1) driveOps(sel, sm, a, b, 1'b0);
        end
        checkOutput({tag, "_latency"}, 64'(doneAt), 64'(np + 2));
        checkOutput({tag, "_doneCount"}, 64'(doneCnt), 64'd1);
        checkOutput({tag, "_busyWindow"}, 64'(busyOk), 64'd1);
        checkOutput({tag, "_busyCleared"}, 64'(busyAfter), 64'd0);
    endtask

    task automatic resetMidOp();
        int doneSeen;
        doneSeen = 0;
        @(negedge clk);
        driveOps(0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        @(posedge clk);
        #1 driveOps(0, 1'b0, 32'd0, 32'd0, 1'b0);
        repeat (3) @(negedge clk);
        #1 reset = 1'b1;
        #1;
        checkOutput("resetMid_busy", 64'(bus32.busy), 64'd0);
        checkOutput("resetMid_done", 64'(bus32.done), 64'd0);
        checkOutput("resetMid_product", bus32.product, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (bus32.done) doneSeen++;
        end
        checkOutput("resetMid_noDone", 64'(doneSeen), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic        sm;
        logic [15:0] ra;
        logic [23:0] rb;
        reset = 1'b1;
        driveOps(0, 1'b0, 32'd0, 32'd0, 1'b0);
        driveOps(1, 1'b0, 32'd0, 32'd0, 1'b0);
        repeat (2) @(negedge clk);
        checkOutput("reset_busy32", 64'(bus32.busy), 64'd0);
        checkOutput("reset_done32", 64'(bus32.done), 64'd0);
        checkOutput("reset_product32", bus32.product, 64'd0);
        checkOutput("reset_busy8", 64'(bus8.busy), 64'd0);
        checkOutput("reset_product8", {24'd0, bus8.product}, 64'd0);
        reset = 1'b0;

        applyStimulus(0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 0, "unsignedMax");
        applyStimulus(0, 1'b1, 32'hFFFF_FFFD, 32'h0000_0005, 64'hFFFF_FFFF_FFFF_FFF1, 0, "signedMixed");
        applyStimulus(0, 1'b1, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 0, "signedMinMin");
        applyStimulus(0, 1'b1, 32'h8000_0000, 32'h7FFF_FFFF, 64'hC000_0000_8000_0000, 0, "signedMinMax");
        applyStimulus(0, 1'b0, 32'h8000_0000, 32'h7FFF_FFFF, 64'h3FFF_FFFF_8000_0000, 0, "unsignedMinMax");
        applyStimulus(0, 1'b1, 32'hFFFF_FFF9, 32'h0000_0003, 64'hFFFF_FFFF_FFFF_FFEB, 2, "startWhileBusy");

        resetMidOp();
        applyStimulus(0, 1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFA, 64'h0000_0000_0000_002A, 0, "afterReset");

        applyStimulus(1, 1'b0, 32'h0000_ABCD, 32'h0012_3456, 64'h0000_000C_3789_5ADE, 0, "variantUnsigned");
        applyStimulus(1, 1'b1, 32'h0000_8000, 32'h0000_0002, 64'h0000_00FF_FFFF_0000, 0, "variantSigned");
        for (int n = 0; n < 8; n++) begin
            sm = 1'($urandom_range(0, 1));
            ra = 16'($urandom);
            rb = 24'($urandom);
            applyStimulus(1, sm, {16'd0, ra}, {8'd0, rb}, refProduct8(sm, ra, rb), 0, "variantRandom");
        end

        repeat (3) @(negedge clk);
        checkOutput("pendingQ32", 64'(q32.size()), 64'd0);
        checkOutput("pendingQ8", 64'(q8.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
